fetch_stage: RTL and testbench

- Instruction fetch stage of the RISC-V core. It sits directly upstream of the opcode decoder/control unit.
- Holds the PC and issues one request at a time to instruction memory.
- Presents the fetched word (whose bits [6:0] drive the decoder OPCODE input) with a valid/ready handshake.
- Accepts a branch/jump redirect from the execute stage and discards any in-flight or held instruction that the redirect invalidates.

---
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_stage.sv | 87 ++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage bundle: instruction-memory port plus decoder handshake
// master = fetch stage side, slave = memory/decoder/execute side.
interface fetch_stage_if #(
  parameter int ADDR_W = 32
);
  logic              IMEM_REQ;
  logic [ADDR_W-1:0] IMEM_ADDR;
  logic [31:0]       IMEM_RDATA;
  logic              IMEM_VALID;
  logic              REDIRECT;
  logic [ADDR_W-1:0] REDIRECT_PC;
  logic [31:0]       INSTR;
  logic [ADDR_W-1:0] PC_OUT;
  logic              INSTR_VALID;
  logic              DEC_READY;

  modport master (
    output IMEM_REQ, IMEM_ADDR, INSTR, PC_OUT, INSTR_VALID,
    input  IMEM_RDATA, IMEM_VALID, REDIRECT, REDIRECT_PC, DEC_READY
  );

  modport slave (
    input  IMEM_REQ, IMEM_ADDR, INSTR, PC_OUT, INSTR_VALID,
    output IMEM_RDATA, IMEM_VALID, REDIRECT, REDIRECT_PC, DEC_READY
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - single-outstanding instruction fetch with redirect flush
// PC is the address of the next (or current in-flight) fetch; PC_OUT tags the held word.
module fetch_stage #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic          CLK,
  input  logic          RESET,
  fetch_stage_if.master bus
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_pc_out;
  logic              r_valid;
  logic [ADDR_W-1:0] w_redir_pc;

  assign w_redir_pc = bus.REDIRECT_PC & ~ADDR_W'(3);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_instr  <= NOP_INSTR;
      r_pc_out <= RESET_PC;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_REQ: begin
          // A redirect in the issue cycle makes the just-issued request stale.
          if (bus.REDIRECT) begin
            r_pc    <= w_redir_pc;
            r_state <= S_DROP;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.IMEM_VALID && !bus.REDIRECT) begin
            r_instr  <= bus.IMEM_RDATA;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + ADDR_W'(4);
            r_state  <= S_HOLD;
          end else if (bus.IMEM_VALID) begin
            r_pc    <= w_redir_pc;
            r_state <= S_REQ;
          end else if (bus.REDIRECT) begin
            r_pc    <= w_redir_pc;
            r_state <= S_DROP;
          end
        end
        S_HOLD: begin
          if (bus.REDIRECT) begin
            r_valid <= 1'b0;
            r_pc    <= w_redir_pc;
            r_state <= S_REQ;
          end else if (bus.DEC_READY) begin
            r_valid <= 1'b0;
            r_state <= S_REQ;
          end
        end
        default: begin
          // DROP: wait out the stale response, tracking the newest redirect target.
          if (bus.REDIRECT) begin
            r_pc <= w_redir_pc;
          end
          if (bus.IMEM_VALID) begin
            r_state <= S_REQ;
          end
        end
      endcase
    end
  end

  assign bus.IMEM_REQ    = (r_state == S_REQ) && !RESET;
  assign bus.IMEM_ADDR   = r_pc;
  assign bus.INSTR       = r_instr;
  assign bus.PC_OUT      = r_pc_out;
  assign bus.INSTR_VALID = r_valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
// Inputs change 1ns after the rising edge; outputs are checked at the same point.
module tb_fetch_stage;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  fetch_stage_if #(.ADDR_W(32)) bus ();

  fetch_stage #(
    .ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(32'h00000013)
  ) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.IMEM_VALID  = 1'b0;
    bus.IMEM_RDATA  = 32'h0;
    bus.REDIRECT    = 1'b0;
    bus.REDIRECT_PC = 32'h0;
    bus.DEC_READY   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b1;
    tick(); tick();
    n_tests++; if (bus.IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", bus.IMEM_REQ); end
    n_tests++; if (bus.INSTR !== 32'h00000013) begin n_fail++; $display("FAIL rst_instr got %h want 00000013", bus.INSTR); end
    n_tests++; if (bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", bus.INSTR_VALID); end
    n_tests++; if (bus.PC_OUT !== 32'h0) begin n_fail++; $display("FAIL rst_pc_out got %h want 0", bus.PC_OUT); end
    RESET = 1'b0;
    #1;
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h0) begin n_fail++; $display("FAIL rst_first_req got %b/%h want 1/00000000", bus.IMEM_REQ, bus.IMEM_ADDR); end
  endtask

  task automatic test_basic();
    bus.DEC_READY = 1'b1;
    tick();
    bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'h00500093;
    tick();
    bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.INSTR !== 32'h00500093 || bus.PC_OUT !== 32'h0 || bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL basic_present got %h/%h/%b want 00500093/00000000/1", bus.INSTR, bus.PC_OUT, bus.INSTR_VALID); end
    n_tests++; if (bus.IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL basic_no_req_hold got %b want 0", bus.IMEM_REQ); end
    tick();
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h4 || bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL basic_next_req got %b/%h/%b want 1/00000004/0", bus.IMEM_REQ, bus.IMEM_ADDR, bus.INSTR_VALID); end
  endtask

  task automatic test_stall();
    bus.DEC_READY = 1'b0;
    tick();
    bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'h00100113;
    tick();
    bus.IMEM_VALID = 1'b0; bus.IMEM_RDATA = 32'hdeadbeef;
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (bus.INSTR !== 32'h00100113 || bus.PC_OUT !== 32'h4 || bus.INSTR_VALID !== 1'b1 || bus.IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL stall_cycle%0d got %h/%h/%b/%b want 00100113/00000004/1/0", i, bus.INSTR, bus.PC_OUT, bus.INSTR_VALID, bus.IMEM_REQ); end
      tick();
    end
    bus.DEC_READY = 1'b1;
    tick();
    bus.DEC_READY = 1'b0;
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h8) begin n_fail++; $display("FAIL stall_release got %b/%h want 1/00000008", bus.IMEM_REQ, bus.IMEM_ADDR); end
  endtask

  task automatic test_redirect_wait();
    tick();
    tick();
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h00000103;
    tick();
    bus.REDIRECT = 1'b0; bus.REDIRECT_PC = 32'h0;
    n_tests++; if (bus.IMEM_REQ !== 1'b0 || bus.IMEM_ADDR !== 32'h100 || bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL rw_drop got %b/%h/%b want 0/00000100/0", bus.IMEM_REQ, bus.IMEM_ADDR, bus.INSTR_VALID); end
    bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'hbad0bad0;
    tick();
    bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h100 || bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL rw_refetch got %b/%h/%b want 1/00000100/0", bus.IMEM_REQ, bus.IMEM_ADDR, bus.INSTR_VALID); end
    tick();
    bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'h00208193;
    tick();
    bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.INSTR !== 32'h00208193 || bus.PC_OUT !== 32'h100 || bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL rw_first_valid got %h/%h/%b want 00208193/00000100/1", bus.INSTR, bus.PC_OUT, bus.INSTR_VALID); end
  endtask

  task automatic test_redirect_hold();
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h00000040; bus.DEC_READY = 1'b1;
    tick();
    bus.REDIRECT = 1'b0; bus.DEC_READY = 1'b0;
    n_tests++; if (bus.INSTR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h40) begin n_fail++; $display("FAIL rh_flush got %b/%b/%h want 0/1/00000040", bus.INSTR_VALID, bus.IMEM_REQ, bus.IMEM_ADDR); end
    n_tests++; if (bus.PC_OUT !== 32'h100) begin n_fail++; $display("FAIL rh_pc_out_kept got %h want 00000100", bus.PC_OUT); end
  endtask

  task automatic test_drop_double();
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'h00000200;
    tick();
    n_tests++; if (bus.IMEM_REQ !== 1'b0 || bus.IMEM_ADDR !== 32'h200) begin n_fail++; $display("FAIL dd_first got %b/%h want 0/00000200", bus.IMEM_REQ, bus.IMEM_ADDR); end
    bus.REDIRECT_PC = 32'h00000300; bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'h12345678;
    tick();
    bus.REDIRECT = 1'b0; bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h300 || bus.INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL dd_second got %b/%h/%b want 1/00000300/0", bus.IMEM_REQ, bus.IMEM_ADDR, bus.INSTR_VALID); end
  endtask

  task automatic test_wrap_reset();
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 32'hfffffffc;
    tick();
    bus.REDIRECT = 1'b0; bus.IMEM_VALID = 1'b1;
    tick();
    bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'hfffffffc) begin n_fail++; $display("FAIL wr_top_req got %b/%h want 1/fffffffc", bus.IMEM_REQ, bus.IMEM_ADDR); end
    tick();
    bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'h00000537; bus.DEC_READY = 1'b1;
    tick();
    bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.INSTR !== 32'h00000537 || bus.PC_OUT !== 32'hfffffffc) begin n_fail++; $display("FAIL wr_top_instr got %h/%h want 00000537/fffffffc", bus.INSTR, bus.PC_OUT); end
    tick();
    bus.DEC_READY = 1'b0;
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h0) begin n_fail++; $display("FAIL wr_wrap got %b/%h want 1/00000000", bus.IMEM_REQ, bus.IMEM_ADDR); end
    tick();
    RESET = 1'b1;
    tick();
    n_tests++; if (bus.IMEM_REQ !== 1'b0 || bus.INSTR !== 32'h00000013 || bus.INSTR_VALID !== 1'b0 || bus.PC_OUT !== 32'h0) begin n_fail++; $display("FAIL wr_reset got %b/%h/%b/%h want 0/00000013/0/00000000", bus.IMEM_REQ, bus.INSTR, bus.INSTR_VALID, bus.PC_OUT); end
    RESET = 1'b0;
    #1;
    n_tests++; if (bus.IMEM_REQ !== 1'b1 || bus.IMEM_ADDR !== 32'h0) begin n_fail++; $display("FAIL wr_post_reset got %b/%h want 1/00000000", bus.IMEM_REQ, bus.IMEM_ADDR); end
    bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'hcafef00d;
    tick();
    bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.INSTR_VALID !== 1'b0 || bus.IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL wr_stray_ignored got %b/%b want 0/0", bus.INSTR_VALID, bus.IMEM_REQ); end
    bus.IMEM_VALID = 1'b1; bus.IMEM_RDATA = 32'h00a00093;
    tick();
    bus.IMEM_VALID = 1'b0;
    n_tests++; if (bus.INSTR !== 32'h00a00093 || bus.PC_OUT !== 32'h0 || bus.INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL wr_after_stray got %h/%h/%b want 00a00093/00000000/1", bus.INSTR, bus.PC_OUT, bus.INSTR_VALID); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_drop_double();
    test_wrap_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
